// File: rtl/dma_write_credit_arbiter.sv
// Round-robin, credit-gated arbiter sharing one single-beat AXI write port among NREQ DMA requesters.
// Optional B-response watchdog is enabled by defining DMA_WRCTRL_TIMEOUT_EN.
module dma_write_credit_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 49,
    parameter int DATA_W  = 128,
    parameter int ID_W    = 6,
    parameter int CREDITS = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clock,
    input  logic                          RESETn,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*ADDR_W-1:0]        req_addr,
    input  logic [NREQ*DATA_W-1:0]        req_data,
    input  logic [NREQ*(DATA_W/8)-1:0]    req_strb,
    output logic [NREQ-1:0]               rsp_valid,
    input  logic [NREQ-1:0]               rsp_ready,
    output logic [1:0]                    rsp_resp,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [ID_W-1:0]               m_awid,
    output logic [ADDR_W-1:0]             m_awaddr,
    output logic [7:0]                    m_awlen,
    output logic [2:0]                    m_awsize,
    output logic [1:0]                    m_awburst,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W/8-1:0]           m_wstrb,
    output logic                          m_wlast,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    input  logic [ID_W-1:0]               m_bid,
    input  logic [1:0]                    m_bresp,
    output logic [$clog2(CREDITS+1)-1:0]  credits_avail,
    output logic                          bid_err,
    output logic                          timeout_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W  = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] hi_idx;
    logic [PTR_W-1:0] lo_idx;
    logic             hi_found;
    logic             grant;
    logic             aw_done;
    logic             w_done;
    logic             aw_fire;
    logic             w_fire;
    logic             b_fire;
    logic             bid_in_range;

    assign m_awlen   = 8'd0;
    assign m_awsize  = 3'($clog2(STRB_W));
    assign m_awburst = 2'b01;
    assign m_wlast   = 1'b1;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = PTR_W'(i);
                if (PTR_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    // Credit check uses the registered count, so a same-cycle B never unblocks a grant at zero.
    assign grant = (state == IDLE) && (credits_avail != '0) && (|req_valid);

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[grant_idx] = 1'b1;
    end

    assign aw_fire = m_awvalid && m_awready;
    assign w_fire  = m_wvalid && m_wready;

    // B routing: unknown IDs are accepted and dropped so the bus never stalls on them.
    assign bid_in_range = (m_bid < ID_W'(NREQ));
    assign rsp_resp     = m_bresp;

    always_comb begin
        rsp_valid = '0;
        m_bready  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (m_bid == ID_W'(i)) begin
                rsp_valid[i] = m_bvalid;
                m_bready     = rsp_ready[i];
            end
        end
    end

    assign b_fire = m_bvalid && m_bready;

    // NOTE: the captured write payload is qualified by the valid flags, so it carries no reset.
    always_ff @(posedge clock) begin
        if (grant) begin
            m_awid   <= ID_W'(grant_idx);
            m_awaddr <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            m_wdata  <= req_data[grant_idx*DATA_W +: DATA_W];
            m_wstrb  <= req_strb[grant_idx*STRB_W +: STRB_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge RESETn) begin
        if (!RESETn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_awvalid     <= 1'b0;
            m_wvalid      <= 1'b0;
            credits_avail <= CREDITS_MAX;
            bid_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= ISSUE;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        rr_ptr    <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                ISSUE: begin
                    if (aw_fire) begin
                        m_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        m_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            case ({grant, b_fire})
                2'b10: credits_avail <= credits_avail - 1'b1;
                2'b01: if (credits_avail != CREDITS_MAX) credits_avail <= credits_avail + 1'b1;
                default: ;
            endcase

            if (b_fire && (!bid_in_range || (!grant && credits_avail == CREDITS_MAX)))
                bid_err <= 1'b1;
        end
    end

`ifdef DMA_WRCTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wd_cnt;

    // Watchdog runs only while writes are outstanding; any B restarts the wait.
    always_ff @(posedge clock or negedge RESETn) begin
        if (!RESETn) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (b_fire || credits_avail == CREDITS_MAX) begin
            wd_cnt <= '0;
        end else if (wd_cnt != TO_W'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == TO_W'(TIMEOUT - 1)) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dma_write_credit_arbiter.sv
// Directed bench for dma_write_credit_arbiter with NREQ=2, CREDITS=4, TIMEOUT=64.
// Expected timeout_err follows DMA_WRCTRL_TIMEOUT_EN when the bench is compiled alongside the RTL.
module tb_dma_write_credit_arbiter;

    localparam int NREQ = 2;
    localparam int ADDR_W = 49;
    localparam int DATA_W = 128;
    localparam int ID_W = 6;

`ifdef DMA_WRCTRL_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic                       clock = 1'b0;
    logic                       RESETn = 1'b0;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*ADDR_W-1:0]     req_addr;
    logic [NREQ*DATA_W-1:0]     req_data;
    logic [NREQ*DATA_W/8-1:0]   req_strb;
    logic [NREQ-1:0]            rsp_valid;
    logic [NREQ-1:0]            rsp_ready;
    logic [1:0]                 rsp_resp;
    logic                       m_awvalid, m_awready;
    logic [ID_W-1:0]            m_awid;
    logic [ADDR_W-1:0]          m_awaddr;
    logic [7:0]                 m_awlen;
    logic [2:0]                 m_awsize;
    logic [1:0]                 m_awburst;
    logic                       m_wvalid, m_wready;
    logic [DATA_W-1:0]          m_wdata;
    logic [DATA_W/8-1:0]        m_wstrb;
    logic                       m_wlast;
    logic                       m_bvalid, m_bready;
    logic [ID_W-1:0]            m_bid;
    logic [1:0]                 m_bresp;
    logic [2:0]                 credits_avail;
    logic                       bid_err, timeout_err;

    int n_checks = 0;
    int n_fail = 0;

    dma_write_credit_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .CREDITS(4), .TIMEOUT(64)
    ) dut (
        .clock(clock), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .credits_avail(credits_avail), .bid_err(bid_err), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        RESETn    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        rsp_ready = '1;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        m_bvalid  = 1'b0;
        m_bid     = '0;
        m_bresp   = 2'b00;
        repeat (2) tick();
        RESETn = 1'b1;
        #1;
    endtask

    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        apply_reset();
        check("rst_credits", credits_avail, 3'd4);
        check("rst_awvalid", m_awvalid, 1'b0);
        check("rst_wvalid", m_wvalid, 1'b0);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_bid_err", bid_err, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);

        // Single write from requester 0
        req_valid = 2'b01;
        req_addr[0 +: ADDR_W] = 49'hDE00;
        req_data[0 +: DATA_W] = 128'hDEADBEEF;
        req_strb[0 +: 16]     = 16'hFFFF;
        #1;
        check("t1_req_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("t1_awvalid", m_awvalid, 1'b1);
        check("t1_wvalid", m_wvalid, 1'b1);
        check("t1_awid", m_awid, 6'd0);
        check("t1_awaddr", m_awaddr, 49'hDE00);
        check("t1_wdata", m_wdata, 128'hDEADBEEF);
        check("t1_wstrb", m_wstrb, 16'hFFFF);
        check("t1_awlen", m_awlen, 8'd0);
        check("t1_awsize", m_awsize, 3'd4);
        check("t1_awburst", m_awburst, 2'b01);
        check("t1_wlast", m_wlast, 1'b1);
        check("t1_credits_dec", credits_avail, 3'd3);
        tick();
        check("t1_aw_drop", m_awvalid, 1'b0);
        m_bvalid  = 1'b1;
        m_bid     = 6'd0;
        m_bresp   = 2'b10;
        rsp_ready = 2'b01;
        #1;
        check("t1_rsp_valid", rsp_valid, 2'b01);
        check("t1_rsp_resp", rsp_resp, 2'b10);
        check("t1_bready", m_bready, 1'b1);
        tick();
        m_bvalid = 1'b0;
        check("t1_credits_ret", credits_avail, 3'd4);

        // Round-robin until the pool is empty
        apply_reset();
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t2_grant", req_ready, exp_g[k]);
            tick();
            check("t2_credits", credits_avail, 3'(4 - (k + 1)));
            tick();
        end
        check("t2_stall", req_ready, 2'b00);
        tick();
        check("t2_stall_aw", m_awvalid, 1'b0);
        check("t2_stall2", req_ready, 2'b00);
        req_valid = 2'b10;
        m_bvalid  = 1'b1;
        m_bid     = 6'd1;
        m_bresp   = 2'b00;
        rsp_ready = 2'b11;
        #1;
        check("t2_rsp_valid", rsp_valid, 2'b10);
        check("t2_no_same_cycle_grant", req_ready, 2'b00);
        tick();
        m_bvalid = 1'b0;
        #1;
        check("t2_credit_back", credits_avail, 3'd1);
        check("t2_regrant", req_ready, 2'b10);
        tick();
        check("t2_regrant_id", m_awid, 6'd1);
        check("t2_regrant_cred", credits_avail, 3'd0);
        tick();
        check("t2_final_stall", req_ready, 2'b00);
        req_valid = 2'b00;

        // AW stalled while W completes
        apply_reset();
        m_awready = 1'b0;
        req_valid = 2'b01;
        req_addr[0 +: ADDR_W] = 49'h1234;
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_awvalid_hold", m_awvalid, 1'b1);
            check("t3_awaddr_hold", m_awaddr, 49'h1234);
            check("t3_wvalid", m_wvalid, (i == 0) ? 1'b1 : 1'b0);
            check("t3_no_grant", req_ready, 2'b00);
            tick();
        end
        m_awready = 1'b1;
        #1;
        check("t3_no_grant_pre_aw", req_ready, 2'b00);
        tick();
        check("t3_aw_drop", m_awvalid, 1'b0);
        check("t3_next_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();

        // Grant and B in the same cycle, then a stray B ID
        apply_reset();
        req_valid = 2'b01;
        repeat (4) tick();
        check("t4_credits2", credits_avail, 3'd2);
        m_bvalid  = 1'b1;
        m_bid     = 6'd0;
        rsp_ready = 2'b01;
        #1;
        check("t4_grant", req_ready, 2'b01);
        check("t4_bready", m_bready, 1'b1);
        tick();
        req_valid = 2'b00;
        m_bvalid  = 1'b0;
        check("t4_credits_same", credits_avail, 3'd2);
        tick();
        m_bvalid  = 1'b1;
        m_bid     = 6'd7;
        rsp_ready = 2'b00;
        #1;
        check("t4_bad_bready", m_bready, 1'b1);
        check("t4_bad_rsp_valid", rsp_valid, 2'b00);
        check("t4_bid_err_pre", bid_err, 1'b0);
        tick();
        m_bvalid = 1'b0;
        check("t4_bid_err", bid_err, 1'b1);
        check("t4_bad_credit_ret", credits_avail, 3'd3);

        // Reset asserted while a write is in flight
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        tick();
        tick();
        m_awready = 1'b0;
        tick();
        req_valid = 2'b00;
        check("t5_pre_credits", credits_avail, 3'd1);
        check("t5_pre_awvalid", m_awvalid, 1'b1);
        RESETn = 1'b0;
        #1;
        check("t5_awvalid", m_awvalid, 1'b0);
        check("t5_credits", credits_avail, 3'd4);
        check("t5_bid_err", bid_err, 1'b0);
        check("t5_timeout_err", timeout_err, 1'b0);
        tick();
        RESETn    = 1'b1;
        m_awready = 1'b1;
        req_valid = 2'b11;
        #1;
        check("t5_rr_ptr0", req_ready, 2'b01);

        // One outstanding write with no B response
        tick();
        req_valid = 2'b00;
        repeat (60) tick();
        check("t6_no_timeout_yet", timeout_err, 1'b0);
        repeat (10) tick();
        check("t6_timeout", timeout_err, TO_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
